sha256_sched: RTL and testbench

SHA256_SCHED -- requirements
Module: sha256_sched

---
 rtl/sha256_pkg.sv | 44 ++++
 rtl/sha256_wexp.sv | 15 +
 rtl/sha256_sched.sv | 162 ++++++++++++++++
 tb/tb_sha256_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types, constants and message-schedule helpers for the SHA-256 scheduler.
package sha256_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned SCHED_WORDS = 64;
  localparam int unsigned HASH_WORDS  = 8;
  localparam int unsigned BLOCK_W     = WORD_W * BLOCK_WORDS;
  localparam int unsigned HASH_W      = WORD_W * HASH_WORDS;
  localparam int unsigned SCHED_W     = WORD_W * SCHED_WORDS;
  localparam int unsigned TCNT_W      = 6;
  localparam int unsigned WDOG_CYCLES = 96;
  localparam int unsigned WDOG_W      = 7;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXPAND  = 3'd1,
    LAUNCH  = 3'd2,
    RUN     = 3'd3,
    CAPTURE = 3'd4,
    RESP    = 3'd5
  } state_t;

  // Standard initial hash value, H0 in the MSBs.
  localparam logic [HASH_W-1:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t ror(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t sigma0(input word_t x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_wexp.sv
// Single-step message schedule word generator: W[t] from W[t-2], W[t-7], W[t-15], W[t-16].
module sha256_wexp
  import sha256_pkg::*;
(
  input  word_t w_tm2,
  input  word_t w_tm7,
  input  word_t w_tm15,
  input  word_t w_tm16,
  output word_t w_c
);

  // Modular sum wraps naturally at 32 bits.
  assign w_c = sigma1(w_tm2) + w_tm7 + sigma0(w_tm15) + w_tm16;

endmodule

// File: rtl/sha256_sched.sv
// Round-robin front end that expands one block per request, drives an external
// compression core and returns chaining value + core result to the requester.
module sha256_sched
  import sha256_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*BLOCK_W-1:0] req_block,
  input  logic [NREQ*HASH_W-1:0]  req_h,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [HASH_W-1:0]       rsp_digest,
  output logic                    core_reset,
  output logic [HASH_W-1:0]       core_h_in,
  output logic [SCHED_W-1:0]      core_w,
  input  logic                    core_done,
  input  logic [HASH_W-1:0]       core_h_out,
  output logic                    busy
);

  state_t              state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q;
  logic [IDW-1:0]      id_q;
  logic [IDW-1:0]      grant_idx;
  logic [IDW-1:0]      cand;
  logic                grant_found;
  logic                grant_go;
  logic                busy_d;
  logic                core_reset_d;
  logic                rsp_valid_d;
  logic [TCNT_W-1:0]   t_q;
  logic [WDOG_W-1:0]   run_cnt_q;
  word_t               w_q [SCHED_WORDS];
  word_t               h_q [HASH_WORDS];
  word_t               w_new_c;
  logic [BLOCK_W-1:0]  blk_arr [NREQ];
  logic [HASH_W-1:0]   h_arr   [NREQ];
  logic [BLOCK_W-1:0]  blk_sel;
  logic [HASH_W-1:0]   h_sel;

  // Split the flat request buses into per-requester slices.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign blk_arr[g] = req_block[g*BLOCK_W +: BLOCK_W];
    assign h_arr[g]   = req_h[g*HASH_W +: HASH_W];
  end

  assign blk_sel = blk_arr[grant_idx];
  assign h_sel   = h_arr[grant_idx];

  // Round-robin search from rr_ptr; req_ready is a combinational grant in IDLE only.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    req_ready   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_go = (state_q == IDLE) && grant_found;
    if (grant_go) req_ready[grant_idx] = 1'b1;
  end

  // Next-state logic plus next values of the registered status outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_go) state_d = EXPAND;
      EXPAND:  if (t_q == TCNT_W'(SCHED_WORDS - 1)) state_d = LAUNCH;
      LAUNCH:  state_d = RUN;
      RUN:     if (core_done || run_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d       = (state_d != IDLE);
    core_reset_d = (state_d != RUN);
    rsp_valid_d  = (state_d == RESP);
  end

  // Control state, round-robin pointer and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      busy       <= 1'b0;
      core_reset <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_digest <= '0;
    end else begin
      state_q    <= state_d;
      busy       <= busy_d;
      core_reset <= core_reset_d;
      rsp_valid  <= rsp_valid_d;
      if (grant_go) begin
        rr_ptr_q <= (32'(grant_idx) == NREQ - 1) ? '0 : IDW'(32'(grant_idx) + 32'd1);
      end
      if (state_q == CAPTURE) begin
        rsp_id <= id_q;
        for (int unsigned i = 0; i < HASH_WORDS; i++) begin
          rsp_digest[HASH_W-1-WORD_W*i -: WORD_W] <=
            h_q[i] + core_h_out[HASH_W-1-WORD_W*i -: WORD_W];
        end
      end
    end
  end

  // Request latch, schedule expansion (one word per cycle) and RUN watchdog counter.
  always_ff @(posedge clk) begin
    if (grant_go) begin
      for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
        w_q[i] <= blk_sel[BLOCK_W-1-WORD_W*i -: WORD_W];
      end
      for (int unsigned i = 0; i < HASH_WORDS; i++) begin
        h_q[i] <= h_sel[HASH_W-1-WORD_W*i -: WORD_W];
      end
      t_q  <= TCNT_W'(BLOCK_WORDS);
      id_q <= grant_idx;
    end
    if (state_q == EXPAND) begin
      w_q[t_q] <= w_new_c;
      t_q      <= t_q + TCNT_W'(1);
    end
    if (state_q == LAUNCH) begin
      run_cnt_q <= '0;
    end else if (state_q == RUN) begin
      run_cnt_q <= run_cnt_q + WDOG_W'(1);
    end
  end

  // One schedule generator, taps selected by the expansion counter.
  sha256_wexp u_wexp (
    .w_tm2  (w_q[t_q - TCNT_W'(2)]),
    .w_tm7  (w_q[t_q - TCNT_W'(7)]),
    .w_tm15 (w_q[t_q - TCNT_W'(15)]),
    .w_tm16 (w_q[t_q - TCNT_W'(16)]),
    .w_c    (w_new_c)
  );

  // Present the held schedule and chaining value to the core, word 0 in the MSBs.
  always_comb begin
    core_w    = '0;
    core_h_in = '0;
    for (int unsigned i = 0; i < SCHED_WORDS; i++) begin
      core_w[SCHED_W-1-WORD_W*i -: WORD_W] = w_q[i];
    end
    for (int unsigned i = 0; i < HASH_WORDS; i++) begin
      core_h_in[HASH_W-1-WORD_W*i -: WORD_W] = h_q[i];
    end
  end

endmodule

// File: tb/tb_sha256_sched.sv
// Directed bench for sha256_sched with a behavioural compression core.
module tb_sha256_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] DIG_ABC = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };
  localparam logic [511:0] BLK_L1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_L2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_L = {
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1
  };

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*512-1:0]  req_block;
  logic [NREQ*256-1:0]  req_h;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [255:0]         rsp_digest;
  logic                 core_reset;
  logic [255:0]         core_h_in;
  logic [2047:0]        core_w;
  logic                 core_done;
  logic [255:0]         core_h_out;
  logic                 busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sha256_sched #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_block  (req_block),
    .req_h      (req_h),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_digest (rsp_digest),
    .core_reset (core_reset),
    .core_h_in  (core_h_in),
    .core_w     (core_w),
    .core_done  (core_done),
    .core_h_out (core_h_out),
    .busy       (busy)
  );

  // Reference SHA-256 pieces.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [2047:0] expand(input logic [511:0] blk);
    logic [31:0]   w [64];
    logic [31:0]   s0, s1;
    logic [2047:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int t = 0; t < 64; t++) r[2047-32*t -: 32] = w[t];
    return r;
  endfunction

  function automatic logic [255:0] rounds(input logic [255:0] h, input logic [2047:0] w);
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    {a, b, c, d, e, f, g, hh} = h;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t]
         + w[2047-32*t -: 32];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a, b, c, d, e, f, g, hh};
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
    logic [255:0] v, r;
    v = rounds(h, expand(blk));
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = h[255-32*i -: 32] + v[255-32*i -: 32];
    return r;
  endfunction

  // Behavioural core: working variables ready while held in reset, done after core_lat RUN cycles.
  int           core_lat = 5;
  bit           done_en  = 1'b1;
  int           run_cnt  = 0;
  logic [255:0] core_res = '0;

  always @(posedge clk) begin
    if (core_reset) begin
      run_cnt  <= 0;
      core_res <= rounds(core_h_in, core_w);
    end else begin
      run_cnt <= run_cnt + 1;
    end
  end

  assign core_done  = done_en && !core_reset && (run_cnt == core_lat - 1);
  assign core_h_out = core_res;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic submit(input int id, input logic [511:0] blk, input logic [255:0] h);
    req_block[id*512 +: 512] = blk;
    req_h[id*256 +: 256]     = h;
    req_valid[id]            = 1'b1;
  endtask

  task automatic wait_any_grant(output bit ok);
    ok = 1'b0;
    #1;
    for (int i = 0; i < 400; i++) begin
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("grant_timeout", 256'(req_ready), 256'(1));
  endtask

  // Counts cycles from the grant cycle to the first cycle with rsp_valid high.
  task automatic wait_rsp(input int id, input bit drop_valid, output int lat);
    lat = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      lat++;
      if (drop_valid && lat == 1) req_valid[id] = 1'b0;
      if (rsp_valid) break;
    end
    if (!rsp_valid) check("rsp_timeout", 256'(rsp_valid), 256'(1));
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    check("rsp_valid_drop", 256'(rsp_valid), 256'(0));
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit           ok;
    int           lat;
    int           gidx;
    int           seen;
    logic [511:0] blk;
    logic [255:0] exp_rr [4];
    logic [255:0] exp1, exp2, exp3;

    reset     = 1'b1;
    req_valid = '0;
    req_block = '0;
    req_h     = '0;
    rsp_ready = 1'b0;
    tick(); tick(); tick();

    // Reset state
    check("rst_req_ready",  256'(req_ready),  256'(0));
    check("rst_rsp_valid",  256'(rsp_valid),  256'(0));
    check("rst_rsp_id",     256'(rsp_id),     256'(0));
    check("rst_rsp_digest", rsp_digest,       256'(0));
    check("rst_core_reset", 256'(core_reset), 256'(1));
    check("rst_busy",       256'(busy),       256'(0));
    reset = 1'b0;
    tick();

    // "abc" on requester 0, core latency 5
    core_lat = 5;
    submit(0, BLK_ABC, IV);
    wait_any_grant(ok);
    check("abc_grant", 256'(req_ready), 256'(4'b0001));
    wait_rsp(0, 1'b1, lat);
    check("abc_latency", 256'(lat), 256'(56));
    check("abc_w16", 256'(core_w[1535 -: 32]), 256'(32'h61626380));
    check("abc_w17", 256'(core_w[1503 -: 32]), 256'(32'h000f0000));
    check("abc_id", 256'(rsp_id), 256'(0));
    check("abc_digest", rsp_digest, DIG_ABC);
    check("abc_busy", 256'(busy), 256'(1));
    check("abc_core_reset_resp", 256'(core_reset), 256'(1));
    consume();

    // Round robin, all requesters valid, consumer always ready
    reset = 1'b1;
    tick();
    reset = 1'b0;
    core_lat  = 2;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      blk = BLK_ABC;
      blk[479:448] = 32'(i + 1);
      exp_rr[i] = compress(IV, blk);
      submit(i, blk, IV);
    end
    for (int g = 0; g < 5; g++) begin
      wait_any_grant(ok);
      check($sformatf("rr%0d_onehot", g), 256'($countones(req_ready)), 256'(1));
      gidx = 0;
      for (int b = 0; b < NREQ; b++) if (req_ready[b]) gidx = b;
      check($sformatf("rr%0d_order", g), 256'(gidx), 256'(g % 4));
      wait_rsp(0, 1'b0, lat);
      check($sformatf("rr%0d_latency", g), 256'(lat), 256'(53));
      check($sformatf("rr%0d_id", g), 256'(rsp_id), 256'(g % 4));
      check($sformatf("rr%0d_digest", g), rsp_digest, exp_rr[g % 4]);
      if (g == 4) req_valid = '0;
      tick();
    end
    rsp_ready = 1'b0;
    check("rr_done_idle", 256'(busy), 256'(0));

    // Backpressure in RESP with another requester waiting
    core_lat = 3;
    blk = BLK_ABC;
    blk[447:416] = 32'hdeadbeef;
    exp1 = compress(IV, blk);
    submit(1, blk, IV);
    wait_any_grant(ok);
    check("bp_grant", 256'(req_ready), 256'(4'b0010));
    wait_rsp(1, 1'b1, lat);
    blk = BLK_ABC;
    blk[31:0] = 32'h12345678;
    exp3 = compress(exp1, blk);
    submit(3, blk, exp1);
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("bp%0d_valid", c), 256'(rsp_valid), 256'(1));
      check($sformatf("bp%0d_digest", c), rsp_digest, exp1);
      check($sformatf("bp%0d_id", c), 256'(rsp_id), 256'(1));
      check($sformatf("bp%0d_ready", c), 256'(req_ready), 256'(0));
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_handshake_no_grant", 256'(req_ready), 256'(0));
    tick();
    rsp_ready = 1'b0;
    check("bp_next_grant", 256'(req_ready), 256'(4'b1000));
    wait_rsp(3, 1'b1, lat);
    check("bp_req3_id", 256'(rsp_id), 256'(3));
    check("bp_req3_digest", rsp_digest, exp3);
    consume();

    // Reset while RUN: request dropped, no response
    core_lat = 30;
    submit(2, BLK_ABC, IV);
    wait_any_grant(ok);
    tick();
    req_valid = '0;
    repeat (59) tick();
    check("mid_run_busy", 256'(busy), 256'(1));
    check("mid_run_core_reset", 256'(core_reset), 256'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("run_rst_busy", 256'(busy), 256'(0));
    check("run_rst_core_reset", 256'(core_reset), 256'(1));
    check("run_rst_rsp_valid", 256'(rsp_valid), 256'(0));
    check("run_rst_req_ready", 256'(req_ready), 256'(0));
    seen = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("run_rst_no_rsp", 256'(seen), 256'(0));

    // Two-block chaining
    core_lat = 7;
    exp1 = compress(IV, BLK_L1);
    exp2 = compress(exp1, BLK_L2);
    submit(0, BLK_L1, IV);
    wait_any_grant(ok);
    wait_rsp(0, 1'b1, lat);
    check("chain1_latency", 256'(lat), 256'(58));
    check("chain1_digest", rsp_digest, exp1);
    consume();
    submit(0, BLK_L2, exp1);
    wait_any_grant(ok);
    wait_rsp(0, 1'b1, lat);
    check("chain2_digest", rsp_digest, exp2);
    check("chain2_known", rsp_digest, DIG_L);
    consume();

    // Watchdog: core never completes
    done_en = 1'b0;
    submit(1, BLK_ABC, IV);
    wait_any_grant(ok);
    check("wdog_grant", 256'(req_ready), 256'(4'b0010));
    wait_rsp(1, 1'b1, lat);
    check("wdog_latency", 256'(lat), 256'(147));
    check("wdog_id", 256'(rsp_id), 256'(1));
    consume();
    done_en = 1'b1;
    check("wdog_idle", 256'(busy), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
